// File: rtl/apb_slave_mem.sv
// APB3 slave backed by a word-addressed register memory with a fixed number of
// wait states and an error response for out-of-range or misaligned addresses.
module apb_slave_mem #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int BYTE_LSB = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int CNT_W    = 4;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    write_q, write_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0]   word_addr;
    logic                    out_of_range;
    logic                    misaligned;
    logic                    mem_we;

    // Any set bit above the index field means the word lies beyond the memory.
    assign word_addr    = paddr >> BYTE_LSB;
    assign out_of_range = |word_addr[ADDR_WIDTH-1:IDX_W];

    generate
        if (BYTE_LSB > 0) begin : g_align
            assign misaligned = |paddr[BYTE_LSB-1:0];
        end else begin : g_no_align
            assign misaligned = 1'b0;
        end
    endgenerate

    // Completion is a function of registered state only.
    assign pready  = (state_q == ACCESS) && (cnt_q == '0);
    assign pslverr = pready && err_q;
    assign prdata  = (pready && !err_q) ? mem_q[idx_q] : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        write_d = write_q;
        err_d   = err_q;
        wdata_d = wdata_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_W'(WAIT_STATES);
                    idx_d   = word_addr[IDX_W-1:0];
                    write_d = pwrite;
                    err_d   = out_of_range || misaligned;
                    wdata_d = pwdata;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_d = IDLE;
                end else if (penable) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        state_d = IDLE;
                        mem_we  = write_q && !err_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            write_q <= write_d;
            err_q   <= err_d;
            wdata_q <= wdata_d;
        end
    end

    // Memory is cleared by reset, so it is held in flops rather than RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: two instances (0 and 3 wait states) checked every
// cycle against a transaction-level model, plus literal per-transfer checks.
module tb_apb_slave_mem;

    logic        clk;
    logic        rst_n;
    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic [31:0] paddr   [2];
    logic [31:0] pwdata  [2];
    logic [31:0] prdata  [2];
    logic        pready  [2];
    logic        pslverr [2];

    logic        exp_pready  [2];
    logic        exp_pslverr [2];
    logic [31:0] exp_prdata  [2];
    logic [31:0] mdl [2][256];

    int errors = 0;
    int checks = 0;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        apb_slave_mem #(
            .ADDR_WIDTH (32),
            .DATA_WIDTH (32),
            .MEM_DEPTH  (256),
            .WAIT_STATES(gi * 3)
        ) u_dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .psel   (psel[gi]),
            .penable(penable[gi]),
            .pwrite (pwrite[gi]),
            .paddr  (paddr[gi]),
            .pwdata (pwdata[gi]),
            .prdata (prdata[gi]),
            .pready (pready[gi]),
            .pslverr(pslverr[gi])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("cyc%0d_pready", d),  {31'b0, pready[d]},  {31'b0, exp_pready[d]});
            chk($sformatf("cyc%0d_pslverr", d), {31'b0, pslverr[d]}, {31'b0, exp_pslverr[d]});
            chk($sformatf("cyc%0d_prdata", d),  prdata[d],           exp_prdata[d]);
        end
    end

    task automatic exp_zero(input int d);
        exp_pready[d]  = 1'b0;
        exp_pslverr[d] = 1'b0;
        exp_prdata[d]  = 32'h0;
    endtask

    task automatic bus_idle(input int d);
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
        exp_zero(d);
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 256; i++)
                mdl[d][i] = 32'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            for (int o = 0; o < 2; o++) bus_idle(o);
        end
    endtask

    // One APB transfer; abort_after >= 0 drops psel after that many access cycles.
    task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input int abort_after,
                        output logic [31:0] rdata, output logic err, output int rdy_at);
        int  ws;
        int  idx;
        bit  e;
        bit  aborted;
        ws      = (d == 1) ? 3 : 0;
        e       = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'd256);
        idx     = int'(addr[9:2]);
        rdata   = 32'h0;
        err     = 1'b0;
        rdy_at  = 99;
        aborted = 1'b0;
        @(posedge clk); #1;
        for (int o = 0; o < 2; o++) if (o != d) bus_idle(o);
        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        pwrite[d]  = wr;
        paddr[d]   = addr;
        pwdata[d]  = data;
        exp_zero(d);
        for (int k = 1; k <= ws + 1 && !aborted; k++) begin
            @(posedge clk); #1;
            if (abort_after >= 0 && k > abort_after) begin
                bus_idle(d);
                aborted = 1'b1;
                @(negedge clk);
            end else begin
                penable[d] = 1'b1;
                paddr[d]   = ~addr;   // must be ignored after setup
                pwdata[d]  = ~data;
                if (k == ws + 1) begin
                    exp_pready[d]  = 1'b1;
                    exp_pslverr[d] = e;
                    exp_prdata[d]  = e ? 32'h0 : mdl[d][idx];
                    if (wr && !e) mdl[d][idx] = data;
                end else begin
                    exp_zero(d);
                end
                @(negedge clk);
                if (pready[d] && rdy_at == 99) rdy_at = k;
                if (k == ws + 1) begin
                    rdata = prdata[d];
                    err   = pslverr[d];
                end
            end
        end
        $display("xfer dut=%0d %s addr=%h wdata=%h rdata=%h err=%0d ready_cycle=%0d%s",
                 d, wr ? "WR" : "RD", addr, data, rdata, err, rdy_at, aborted ? " aborted" : "");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          ra;

        rst_n = 1'b0;
        for (int o = 0; o < 2; o++) begin
            bus_idle(o);
            pwrite[o] = 1'b0;
            paddr[o]  = 32'h0;
            pwdata[o] = 32'h0;
        end
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_pready",  {31'b0, pready[0]},  32'h0);
        chk("reset_pslverr", {31'b0, pslverr[1]}, 32'h0);
        chk("reset_prdata",  prdata[0],           32'h0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        idle(1);

        // Fresh memory reads zero, completes in first access cycle.
        xfer(0, 0, 32'h0, 32'h0, -1, rd, er, ra);
        chk("rd0_data", rd, 32'h0);
        chk("rd0_err", {31'b0, er}, 32'h0);
        chk("rd0_latency", ra, 1);

        xfer(0, 1, 32'h10, 32'hDEADBEEF, -1, rd, er, ra);
        chk("wr10_latency", ra, 1);
        xfer(0, 0, 32'h10, 32'h0, -1, rd, er, ra);
        chk("rd10_data", rd, 32'hDEADBEEF);
        chk("rd10_err", {31'b0, er}, 32'h0);

        // Three wait states on the second instance; last word of memory.
        xfer(1, 1, 32'h3FC, 32'h12345678, -1, rd, er, ra);
        chk("wr3fc_latency", ra, 4);
        xfer(1, 0, 32'h3FC, 32'h0, -1, rd, er, ra);
        chk("rd3fc_data", rd, 32'h12345678);
        chk("rd3fc_latency", ra, 4);

        // One past the end: error on both, no aliasing onto word 0.
        xfer(0, 1, 32'h400, 32'hAAAA5555, -1, rd, er, ra);
        chk("wr400_err", {31'b0, er}, 32'h1);
        xfer(0, 0, 32'h400, 32'h0, -1, rd, er, ra);
        chk("rd400_err", {31'b0, er}, 32'h1);
        chk("rd400_data", rd, 32'h0);
        xfer(0, 0, 32'h0, 32'h0, -1, rd, er, ra);
        chk("rd0_noalias", rd, 32'h0);

        // Misaligned write is rejected.
        xfer(0, 1, 32'h02, 32'hCAFEF00D, -1, rd, er, ra);
        chk("wr02_err", {31'b0, er}, 32'h1);
        xfer(0, 0, 32'h0, 32'h0, -1, rd, er, ra);
        chk("rd0_after_unaligned", rd, 32'h0);

        // Back-to-back writes with no idle cycle.
        xfer(0, 1, 32'h04, 32'h04040404, -1, rd, er, ra);
        xfer(0, 1, 32'h08, 32'h08080808, -1, rd, er, ra);
        xfer(0, 0, 32'h04, 32'h0, -1, rd, er, ra);
        chk("rd04_data", rd, 32'h04040404);
        xfer(0, 0, 32'h08, 32'h0, -1, rd, er, ra);
        chk("rd08_data", rd, 32'h08080808);

        // Aborted write leaves the previous contents.
        xfer(1, 1, 32'h20, 32'h5A5A5A5A, -1, rd, er, ra);
        xfer(1, 1, 32'h20, 32'hFFFFFFFF, 1, rd, er, ra);
        chk("abort_no_ready", ra, 99);
        idle(1);
        xfer(1, 0, 32'h20, 32'h0, -1, rd, er, ra);
        chk("rd20_after_abort", rd, 32'h5A5A5A5A);

        // Reset in the middle of a completing read.
        @(posedge clk); #1;
        bus_idle(1);
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b0; paddr[0] = 32'h10;
        exp_zero(0);
        @(posedge clk); #1;
        penable[0]     = 1'b1;
        exp_pready[0]  = 1'b1;
        exp_pslverr[0] = 1'b0;
        exp_prdata[0]  = mdl[0][4];
        #1;
        chk("pre_rst_prdata", prdata[0], 32'hDEADBEEF);
        rst_n = 1'b0;
        for (int o = 0; o < 2; o++) bus_idle(o);
        clear_model();
        #1;
        chk("rst_async_pready",  {31'b0, pready[0]},  32'h0);
        chk("rst_async_pslverr", {31'b0, pslverr[0]}, 32'h0);
        chk("rst_async_prdata",  prdata[0],           32'h0);
        $display("xfer dut=0 RD addr=00000010 interrupted by reset");
        @(posedge clk); #3;
        rst_n = 1'b1;
        xfer(0, 0, 32'h10, 32'h0, -1, rd, er, ra);
        chk("rd10_after_reset", rd, 32'h0);
        xfer(1, 0, 32'h3FC, 32'h0, -1, rd, er, ra);
        chk("rd3fc_after_reset", rd, 32'h0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
